// File: rtl/regfile_pkg.sv
// Shared register-file widths and the dump-reader state encoding.
// Imported by the dump reader and its stream interface.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream carrying (index, value) pairs
// out of the register-file dump reader.
interface regfile_dump_reader_if;
    import regfile_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_index;
    logic [REG_DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register-file read addresses and streams (index, value) beats.
// Build option REGFILE_DUMP_SKIP_ZERO_EN drops beats whose value is zero.
module regfile_dump_reader #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
    parameter int DATA_W   = regfile_pkg::REG_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    regfile_dump_reader_if.master io,
    output logic                 busy,
    output logic                 done
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

    assign hs = valid_q && io.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    idx_d   = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
                else if (rd_data == '0) begin
                    if (idx_q == LAST) state_d = DONE;
                    else idx_d = idx_q + 1'b1;
                end
`endif
                else begin
                    data_d  = rd_data;
                    index_d = idx_q;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // abort wins even when the beat handshakes this cycle
                if (abort) begin
                    idx_d   = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (hs) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == SEND);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_addr      = idx_q;
    assign io.out_valid = valid_q;
    assign io.out_index = index_q;
    assign io.out_data  = data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file
// whose read port is shared with the datapath through a busy-selected mux.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [4:0]  rf_raddr;

    int vectors = 0;
    int miscompares = 0;

    int          exp_idx [$];
    logic [31:0] exp_dat [$];

    regfile_dump_reader_if bus ();

    regfile_dump_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .io      (bus),
        .busy    (busy),
        .done    (done)
    );

    assign rf_raddr = busy ? rd_addr : 5'd0;
    assign rd_data  = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++)
            regs[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + i;
    endtask

    task automatic build_exp();
        logic [31:0] v;
        exp_idx.delete();
        exp_dat.delete();
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'd0 : regs[i];
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
            if (v != 32'd0) begin
                exp_idx.push_back(i);
                exp_dat.push_back(v);
            end
`else
            exp_idx.push_back(i);
            exp_dat.push_back(v);
`endif
        end
    endtask

    task automatic run_dump(input bit rnd, input bit inject);
        int cyc, n, acc_cyc, first_v;
        bit pend, got;
        logic [4:0]  pi;
        logic [31:0] pd;
        n = 0; acc_cyc = -10; first_v = -1; pend = 0; got = 0;
        pi = '0; pd = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!got && cyc < 400) begin
            if (pend) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_index", 32'(bus.out_index), 32'(pi));
                chk("hold_data", bus.out_data, pd);
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (n < exp_idx.size()) begin
                    chk("beat_index", 32'(bus.out_index), 32'(exp_idx[n]));
                    chk("beat_data", bus.out_data, exp_dat[n]);
                end else begin
                    chk("extra_beat", 32'(bus.out_index), 32'hFFFF_FFFF);
                end
                if (inject && bus.out_index == 5'd3) begin
                    regs[10] = 32'hDEAD_BEEF;
                    regs[2]  = 32'h1234_5678;
                end
                n++;
                acc_cyc = cyc;
            end
            pend = bus.out_valid && !bus.out_ready;
            pi = bus.out_index;
            pd = bus.out_data;
            tick();
            cyc++;
            if (done) got = 1;
        end
        bus.out_ready = 1'b1;
        chk("done_seen", 32'(got), 32'd1);
        chk("beat_count", 32'(n), 32'(exp_idx.size()));
        chk("done_after_last", 32'(cyc - acc_cyc), 32'd1);
`ifndef REGFILE_DUMP_SKIP_ZERO_EN
        chk("first_valid_lat", 32'(first_v), 32'd2);
`endif
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_to(input logic [4:0] target);
        int k;
        k = 0;
        bus.out_ready = 1'b1;
        while (!(bus.out_valid && bus.out_index == target) && k < 200) begin
            tick();
            k++;
        end
        chk("reach_index", 32'(k < 200), 32'd1);
    endtask

    initial begin
        int n, beats;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_index", 32'(bus.out_index), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        preload();
        build_exp();
        run_dump(1'b0, 1'b0);

        build_exp();
        run_dump(1'b1, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(5'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(rd_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        build_exp();
        run_dump(1'b0, 1'b0);

        build_exp();
        for (int i = 0; i < exp_idx.size(); i++)
            if (exp_idx[i] == 10) exp_dat[i] = 32'hDEAD_BEEF;
        run_dump(1'b0, 1'b1);
        chk("r2_written", regs[2], 32'h1234_5678);
        preload();

        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(5'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        tick();
        chk("busy_start_valid", 32'(bus.out_valid), 32'd1);
        chk("busy_start_index", 32'(bus.out_index), 32'd6);
        run_to(5'd20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_index", 32'(bus.out_index), 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        tick();

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[5]  = 32'd1;
        regs[31] = 32'd2;
        exp_idx.delete();
        exp_dat.delete();
        exp_idx.push_back(5);
        exp_dat.push_back(32'd1);
        exp_idx.push_back(31);
        exp_dat.push_back(32'd2);
        run_dump(1'b0, 1'b0);

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        beats = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (bus.out_valid) beats++;
            tick();
            n++;
        end
        chk("zero_file_beats", 32'(beats), 32'd0);
        chk("zero_file_done_lat", 32'(n), 32'd33);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
